fetch_queue_unit: RTL

- Parametrised instruction-fetch stage.
- Issues pipelined, in-order requests to I-MEM with up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions in a FQ_DEPTH-entry fetch queue and presents {pc, inst} packets to Decode under a valid/stall handshake.
- Supports PC redirect (branch/jump/trap/flush), which squashes queued and in-flight fetches.

---
 rtl/fetch_queue_unit_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_queue_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_unit_pkg
//  Description : Shared widths, reset PC and fetch-packet field offsets for
//                the instruction-fetch queue unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_unit_pkg;

    localparam int              FQ_ADDR_WIDTH = 32;
    localparam int              FQ_INST_WIDTH = 32;
    localparam int              FQ_PKT_WIDTH  = FQ_ADDR_WIDTH + FQ_INST_WIDTH;
    localparam logic [31:0]     FQ_PC_RESET   = 32'h0000_0000;

    // Packet layout: {pc, inst}, instruction in the low bits
    localparam int              PKT_INST_LSB  = 0;
    localparam int              PKT_PC_LSB    = FQ_INST_WIDTH;

endpackage : fetch_queue_unit_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Generic synchronous FIFO with flush, full/empty and count.
//                DEPTH need not be a power of two. A push while full is only
//                accepted when a pop frees the slot in the same cycle; a pop
//                while empty is ignored. Flush overrides push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_unit
//  Description : Instruction-fetch stage. Issues in-order pipelined requests
//                to I-MEM (up to MAX_OUTSTANDING live), pairs returning
//                instructions with their issued PC, buffers {pc, inst} in a
//                FQ_DEPTH-entry queue and hands packets to Decode under a
//                valid/stall handshake. Redirects flush the queue and mark
//                every in-flight response for discard.
//                Optional macro FETCH_BYPASS_EN: a response arriving at an
//                empty queue is presented to Decode in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = FQ_ADDR_WIDTH,
    parameter int                    INST_WIDTH      = FQ_INST_WIDTH,
    parameter int                    FQ_DEPTH        = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET        = ADDR_WIDTH'(FQ_PC_RESET)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_stall,
    output logic                           o_if_pkt_vld,
    output logic [ADDR_WIDTH+INST_WIDTH-1:0] o_if_pkt_data,
    input  logic                           i_redir,
    input  logic [ADDR_WIDTH-1:0]          i_redir_pc,
    output logic [ADDR_WIDTH-1:0]          o_iaddr,
    output logic                           o_iaddr_vld,
    input  logic                           i_iaddr_rdy,
    input  logic [INST_WIDTH-1:0]          i_inst,
    input  logic                           i_inst_vld
);

    localparam int PKT_W   = ADDR_WIDTH + INST_WIDTH;
    localparam int Q_CNT_W = $clog2(FQ_DEPTH+1);
    localparam int T_CNT_W = $clog2(MAX_OUTSTANDING+1);
    localparam int SUM_W   = $clog2(FQ_DEPTH+MAX_OUTSTANDING+1);
    // Headroom for several back-to-back redirects before old responses drain
    localparam int DISC_W  = T_CNT_W + 4;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DISC_W-1:0]     r_discard;

    logic                  w_q_push;
    logic                  w_q_pop;
    logic                  w_q_full;
    logic                  w_q_empty;
    logic [Q_CNT_W-1:0]    w_q_count;
    logic [PKT_W-1:0]      w_q_head;

    logic                  w_trk_full;
    logic                  w_trk_empty;
    logic [T_CNT_W-1:0]    w_trk_count;
    logic [ADDR_WIDTH-1:0] w_trk_head;

    logic                  w_fire;
    logic                  w_live;
    logic                  w_drop;
    logic [SUM_W-1:0]      w_inflight;
    logic [PKT_W-1:0]      w_resp_pkt;

    assign o_iaddr = r_pc;

    // Issue credit, response classification and Decode-side handshake
    always_comb begin
        w_inflight   = SUM_W'(w_q_count) + SUM_W'(w_trk_count);
        // Live outstanding count equals the issued-PC tracker occupancy
        o_iaddr_vld  = rst_n && !i_redir && !w_trk_full &&
                       (w_inflight < SUM_W'(FQ_DEPTH));
        w_fire       = o_iaddr_vld && i_iaddr_rdy;
        w_live       = i_inst_vld && (r_discard == '0);
        w_drop       = i_inst_vld && (r_discard != '0);
        w_resp_pkt   = {w_trk_head, i_inst};
        w_q_pop      = !w_q_empty && !i_stall && !i_redir;
`ifdef FETCH_BYPASS_EN
        o_if_pkt_vld  = !w_q_empty || w_live;
        o_if_pkt_data = !w_q_empty ? w_q_head :
                        (w_live ? w_resp_pkt : '0);
        // A bypassed packet consumed this cycle never enters the queue
        w_q_push      = w_live && !i_redir && !(w_q_empty && !i_stall);
`else
        o_if_pkt_vld  = !w_q_empty;
        o_if_pkt_data = w_q_empty ? '0 : w_q_head;
        w_q_push      = w_live && !i_redir;
`endif
    end

    // PC and discard-count state; redirect takes priority over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= PC_RESET;
            r_discard <= '0;
        end else if (i_redir) begin
            r_pc      <= i_redir_pc;
            // Every in-flight response (old discards plus live ones) is
            // now stale, less the one returning this cycle
            r_discard <= r_discard + DISC_W'(w_trk_count) + DISC_W'(w_fire)
                         - DISC_W'(i_inst_vld);
        end else begin
            if (w_fire) r_pc      <= r_pc + ADDR_WIDTH'(4);
            if (w_drop) r_discard <= r_discard - DISC_W'(1);
        end
    end

    // Credit accounting must make these conditions unreachable
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_q_push && w_q_full && !w_q_pop));
            assert (!(w_live && w_trk_empty));
        end
    end

    fetch_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_q_push),
        .wdata (w_resp_pkt),
        .pop   (w_q_pop),
        .flush (i_redir),
        .rdata (w_q_head),
        .full  (w_q_full),
        .empty (w_q_empty),
        .count (w_q_count)
    );

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_issued_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fire),
        .wdata (r_pc),
        .pop   (w_live),
        .flush (i_redir),
        .rdata (w_trk_head),
        .full  (w_trk_full),
        .empty (w_trk_empty),
        .count (w_trk_count)
    );

endmodule : fetch_queue_unit
`default_nettype wire
